// File: rtl/collect_pkg.sv
// Shared constants for the collect/distribute micro-switch layer: commands and FSM states.
// No logic; imported by the switch RTL and by benches.
package collect_pkg;

    localparam logic [1:0] CMD_NA   = 2'b00;
    localparam logic [1:0] CMD_LOW  = 2'b01;
    localparam logic [1:0] CMD_HIGH = 2'b10;
    localparam logic [1:0] CMD_BOTH = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Both-branch detection shared by the RTL and models.
    function automatic logic both_valid(input logic [1:0] vld);
        return vld[1] & vld[0];
    endfunction

endpackage

// File: rtl/collect_hold_reg_seq.sv
// Hold register for the deferred low word of a collect-both command.
// Latency 1; load wins over clear; i_en=0 freezes contents.
module collect_hold_reg_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_load,
    input  logic                  i_clr,
    input  logic [DATA_WIDTH-1:0] i_d,
    output logic [DATA_WIDTH-1:0] o_q
);

    logic [DATA_WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (i_en) begin
            if (i_load) begin
                r_q <= i_d;
            end else if (i_clr) begin
                r_q <= '0;
            end
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/collect_2x1_seq.sv
// Sequential 2-to-1 collect switch: merges high/low branches onto one bus, one word per cycle.
// Registered outputs (1 cycle); cmd 11 with both valid drains over 2 cycles with o_ready low.
// Optional COLLECT_ADD_EN: cmd 11 with both valid emits high+low (wrapping) in one cycle instead.
module collect_2x1_seq
    import collect_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int COMMMAND_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                i_valid,
    input  logic [2*DATA_WIDTH-1:0]   i_data_bus,
    output logic                      o_valid,
    output logic [DATA_WIDTH-1:0]     o_data_bus,
    output logic                      o_ready,
    input  logic                      i_en,
    input  logic [COMMMAND_WIDTH-1:0] i_cmd
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;

    logic                  w_valid_nxt;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic                  w_hold_load;
    logic                  w_hold_clr;
    logic [DATA_WIDTH-1:0] w_hold_q;

    logic [DATA_WIDTH-1:0] w_data_hi;
    logic [DATA_WIDTH-1:0] w_data_lo;
    logic                  w_both;

    assign w_data_hi = i_data_bus[2*DATA_WIDTH-1:DATA_WIDTH];
    assign w_data_lo = i_data_bus[DATA_WIDTH-1:0];
    assign w_both    = both_valid(i_valid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else if (i_en) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
`ifndef COLLECT_ADD_EN
                if (i_cmd == CMD_BOTH && w_both) begin
                    w_state_nxt = ST_DRAIN;
                end
`endif
            end
            ST_DRAIN: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_valid_nxt = 1'b0;
        w_data_nxt  = '0;
        w_hold_load = 1'b0;
        w_hold_clr  = 1'b0;
        if (r_state == ST_DRAIN) begin
            // Inputs are ignored here; upstream is stalled by o_ready.
            w_valid_nxt = 1'b1;
            w_data_nxt  = w_hold_q;
            w_hold_clr  = 1'b1;
        end else begin
            case (i_cmd)
                CMD_LOW: begin
                    if (i_valid[0]) begin
                        w_valid_nxt = 1'b1;
                        w_data_nxt  = w_data_lo;
                    end
                end
                CMD_HIGH: begin
                    if (i_valid[1]) begin
                        w_valid_nxt = 1'b1;
                        w_data_nxt  = w_data_hi;
                    end
                end
                CMD_BOTH: begin
                    case (i_valid)
                        2'b01: begin
                            w_valid_nxt = 1'b1;
                            w_data_nxt  = w_data_lo;
                        end
                        2'b10: begin
                            w_valid_nxt = 1'b1;
                            w_data_nxt  = w_data_hi;
                        end
                        2'b11: begin
                            w_valid_nxt = 1'b1;
`ifdef COLLECT_ADD_EN
                            w_data_nxt  = w_data_hi + w_data_lo;
`else
                            w_data_nxt  = w_data_hi;
                            w_hold_load = 1'b1;
`endif
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_en) begin
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
        end
    end

    collect_hold_reg_seq #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_hold (
        .clk    (clk),
        .rst    (rst),
        .i_en   (i_en),
        .i_load (w_hold_load),
        .i_clr  (w_hold_clr),
        .i_d    (w_data_lo),
        .o_q    (w_hold_q)
    );

    assign o_valid    = r_valid;
    assign o_data_bus = r_data;
    assign o_ready    = (r_state == ST_IDLE);

endmodule

// File: tb/tb_collect_2x1_seq.sv
// Bench for collect_2x1_seq: scoreboard of expected outputs fed by a behavioural model,
// plus directed value checks. Honours COLLECT_ADD_EN when defined.
module tb_collect_2x1_seq;
    import collect_pkg::*;

    localparam int W = 32;

    typedef struct packed {
        logic         vld;
        logic [W-1:0] dat;
        logic         rdy;
    } exp_t;

    logic           clk;
    logic           rst;
    logic [1:0]     i_valid;
    logic [2*W-1:0] i_data_bus;
    logic           o_valid;
    logic [W-1:0]   o_data_bus;
    logic           o_ready;
    logic           i_en;
    logic [1:0]     i_cmd;

    int n_checks;
    int n_errors;

    exp_t sb_q[$];

    logic         m_drain;
    logic [W-1:0] m_hold;
    logic         m_vld;
    logic [W-1:0] m_dat;

    collect_2x1_seq #(
        .DATA_WIDTH     (W),
        .COMMMAND_WIDTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_data_bus (i_data_bus),
        .o_valid    (o_valid),
        .o_data_bus (o_data_bus),
        .o_ready    (o_ready),
        .i_en       (i_en),
        .i_cmd      (i_cmd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h required %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_drain = 1'b0;
        m_hold  = '0;
        m_vld   = 1'b0;
        m_dat   = '0;
    endtask

    // Spec-level model of one clock edge; returns the expected post-edge outputs.
    task automatic model_step(input logic en, input logic [1:0] cmd, input logic [1:0] v,
                              input logic [W-1:0] hi, input logic [W-1:0] lo, output exp_t e);
        if (en) begin
            if (m_drain) begin
                m_vld   = 1'b1;
                m_dat   = m_hold;
                m_hold  = '0;
                m_drain = 1'b0;
            end else begin
                m_vld = 1'b0;
                m_dat = '0;
                if (cmd == CMD_LOW && v[0]) begin
                    m_vld = 1'b1; m_dat = lo;
                end else if (cmd == CMD_HIGH && v[1]) begin
                    m_vld = 1'b1; m_dat = hi;
                end else if (cmd == CMD_BOTH && v == 2'b01) begin
                    m_vld = 1'b1; m_dat = lo;
                end else if (cmd == CMD_BOTH && v == 2'b10) begin
                    m_vld = 1'b1; m_dat = hi;
                end else if (cmd == CMD_BOTH && v == 2'b11) begin
                    m_vld = 1'b1;
`ifdef COLLECT_ADD_EN
                    m_dat = hi + lo;
`else
                    m_dat   = hi;
                    m_hold  = lo;
                    m_drain = 1'b1;
`endif
                end
            end
        end
        e.vld = m_vld;
        e.dat = m_dat;
        e.rdy = ~m_drain;
    endtask

    task automatic step(input logic en, input logic [1:0] cmd, input logic [1:0] v,
                        input logic [W-1:0] hi, input logic [W-1:0] lo);
        exp_t e;
        exp_t got;
        i_en       = en;
        i_cmd      = cmd;
        i_valid    = v;
        i_data_bus = {hi, lo};
        model_step(en, cmd, v, hi, lo, e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            got = sb_q.pop_front();
            chk("sb_vld", {63'd0, o_valid}, {63'd0, got.vld});
            chk("sb_dat", {32'd0, o_data_bus}, {32'd0, got.dat});
            chk("sb_rdy", {63'd0, o_ready}, {63'd0, got.rdy});
        end
    endtask

    task automatic async_reset_check(input string tag);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk({tag, "_vld"}, {63'd0, o_valid}, 64'd0);
        chk({tag, "_dat"}, {32'd0, o_data_bus}, 64'd0);
        chk({tag, "_rdy"}, {63'd0, o_ready}, 64'd1);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b0;
        i_en       = 1'b0;
        i_cmd      = CMD_NA;
        i_valid    = 2'b00;
        i_data_bus = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", {63'd0, o_valid}, 64'd0);
        chk("rst_dat", {32'd0, o_data_bus}, 64'd0);
        chk("rst_rdy", {63'd0, o_ready}, 64'd1);
        rst = 1'b1;

        step(1'b1, CMD_LOW, 2'b11, 32'hAAAA_0001, 32'h5555_0002);
        chk("low_dat", {32'd0, o_data_bus}, 64'h5555_0002);
        chk("low_vld", {63'd0, o_valid}, 64'd1);
        step(1'b1, CMD_HIGH, 2'b11, 32'hAAAA_0001, 32'h5555_0002);
        chk("high_dat", {32'd0, o_data_bus}, 64'hAAAA_0001);

        step(1'b1, CMD_BOTH, 2'b11, 32'h1, 32'h2);
`ifdef COLLECT_ADD_EN
        chk("add_dat", {32'd0, o_data_bus}, 64'h3);
        chk("add_rdy", {63'd0, o_ready}, 64'd1);
`else
        chk("both1_dat", {32'd0, o_data_bus}, 64'h1);
        chk("both1_rdy", {63'd0, o_ready}, 64'd0);
        step(1'b1, CMD_LOW, 2'b11, 32'hFF, 32'hEE);
        chk("both2_dat", {32'd0, o_data_bus}, 64'h2);
        chk("both2_rdy", {63'd0, o_ready}, 64'd1);
`endif

        step(1'b1, CMD_BOTH, 2'b01, 32'h0, 32'h7);
        chk("one_dat", {32'd0, o_data_bus}, 64'h7);
        chk("one_rdy", {63'd0, o_ready}, 64'd1);
        step(1'b1, CMD_HIGH, 2'b01, 32'h9, 32'h7);
        chk("nosel_vld", {63'd0, o_valid}, 64'd0);
        chk("nosel_dat", {32'd0, o_data_bus}, 64'd0);
        step(1'b1, CMD_NA, 2'b11, 32'h9, 32'h7);

        // Stall during DRAIN via i_en.
        step(1'b1, CMD_BOTH, 2'b11, 32'h10, 32'h20);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, CMD_NA, 2'b00, 32'h0, 32'h0);
`ifndef COLLECT_ADD_EN
            chk("stall_dat", {32'd0, o_data_bus}, 64'h10);
            chk("stall_rdy", {63'd0, o_ready}, 64'd0);
`endif
        end
        step(1'b1, CMD_NA, 2'b00, 32'h0, 32'h0);
        step(1'b1, CMD_NA, 2'b00, 32'h0, 32'h0);

        step(1'b1, CMD_BOTH, 2'b11, 32'hFFFF_FFFF, 32'h2);
`ifdef COLLECT_ADD_EN
        chk("wrap_dat", {32'd0, o_data_bus}, 64'h1);
        chk("wrap_rdy", {63'd0, o_ready}, 64'd1);
`endif
        step(1'b1, CMD_NA, 2'b00, 32'h0, 32'h0);

        // Async reset mid-stream and mid-DRAIN.
        step(1'b1, CMD_LOW, 2'b01, 32'h0, 32'h33);
        async_reset_check("arst_stream");
        step(1'b1, CMD_BOTH, 2'b11, 32'h44, 32'h55);
        async_reset_check("arst_drain");
        step(1'b1, CMD_NA, 2'b00, 32'h0, 32'h0);
        chk("arst_discard_vld", {63'd0, o_valid}, 64'd0);

        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 32'($urandom), 32'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/collect_2x1_seq.md
Name: collect_2x1_seq

Overview:
Sequential 2-to-1 collect switch, the merge counterpart of the 1x2 distribute switch in the micro-switch layer. It takes data from a high branch and a low branch and places it onto one output bus, one word per cycle. When both branches carry data (cmd 2'b11), it serializes them over two cycles and stalls upstream through o_ready. It is used on the return and gather paths of the NoC trees.

Parameters:
DATA_WIDTH, 32, width of each branch word and of the output word.
COMMMAND_WIDTH, 2, command width; only the value 2 is supported.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  reset; asynchronous, active-low (asserted when 0).
i_valid  input  2  per-branch valid: [1]=high branch, [0]=low branch.
i_data_bus  input  2*DATA_WIDTH  {i_data_high, i_data_low}; high branch = [2*DATA_WIDTH-1:DATA_WIDTH].
o_valid  output  1  output word valid.
o_data_bus  output  DATA_WIDTH  output word; dummy data is all zeros.
o_ready  output  1  upstream may present a new input; low while draining the second word.
i_en  input  1  switch enable; when 0, all state is frozen.
i_cmd  input  2  00=NA, 01=take low, 10=take high, 11=collect both.

Behaviour:
- Reset (rst=0, async): state=IDLE, o_valid=0, o_data_bus=0, hold register=0, o_ready=1. Takes effect immediately, including mid-DRAIN; the pending held word is discarded.
- Latency: registered outputs; an input sampled at edge N appears on the outputs after edge N.
- i_en=0: state, hold register, o_valid and o_data_bus keep their values. o_ready keeps tracking the state.
- o_ready = (state==IDLE). It is combinational from the state register.
- Rules in IDLE with i_en=1:
  - cmd 00, or the selected branch not valid: o_valid<=0, o_data_bus<=0.
  - cmd 01 with i_valid[0]=1: output the low word, o_valid<=1.
  - cmd 10 with i_valid[1]=1: output the high word, o_valid<=1.
  - cmd 11 with exactly one branch valid: pass that word, o_valid<=1, stay in IDLE.
  - cmd 11 with both valid: output the high word, load the low word into the hold register, go to DRAIN.
- DRAIN with i_en=1: output the hold register, o_valid<=1, clear the hold register, return to IDLE. Inputs are ignored in DRAIN; upstream must not change data while o_ready=0.
- Throughput: 1 word/cycle, except 11-with-both, which takes 2 cycles.
- States: IDLE, DRAIN. A 1-bit state register; there is no illegal state.

Optional Feature:
COLLECT_ADD_EN.
- Defined: cmd 11 with both branches valid outputs high+low in a single cycle, no DRAIN. The sum is an unsigned DATA_WIDTH-bit value that wraps modulo 2^DATA_WIDTH; the carry is discarded. o_ready stays 1.
- Undefined: the serialization behaviour above.

Decomposition:
- Shared package collect_pkg holds:
  - CMD_NA=2'b00, CMD_LOW=2'b01, CMD_HIGH=2'b10, CMD_BOTH=2'b11.
  - State encodings ST_IDLE=1'b0, ST_DRAIN=1'b1.
  - The same command constants are reused by distribute_1x2_seq benches.
- Natural sub-module: collect_hold_reg_seq, a DATA_WIDTH hold register with async active-low reset, enable, load and clear.

Test Plan (DATA_WIDTH=32):
- Assert rst=0 mid-stream with o_valid=1 -> o_valid=0, o_data_bus=0 and o_ready=1 immediately, with no clock edge.
- cmd=01, i_valid=2'b11, high=32'hAAAA_0001, low=32'h5555_0002 -> next cycle o_valid=1, o_data_bus=32'h5555_0002; cmd=10 with the same data -> 32'hAAAA_0001.
- cmd=11, i_valid=2'b11, high=32'h1, low=32'h2 ->
  - cycle 1: o_data_bus=32'h1, o_ready=0.
  - cycle 2: o_data_bus=32'h2, o_ready=1.
  - Changed inputs during cycle 2 are ignored.
- cmd=11, i_valid=2'b01, low=32'h7 -> single output 32'h7, o_ready stays 1; cmd=10 with i_valid=2'b01 -> o_valid=0, o_data_bus=0.
- In DRAIN, drop i_en for 3 cycles -> o_data_bus stays the high word and o_ready stays 0; raise i_en -> the low word is emitted once, then IDLE.
- With COLLECT_ADD_EN: cmd=11, high=32'hFFFF_FFFF, low=32'h2 -> o_data_bus=32'h1, o_valid=1, o_ready never drops.
